core_region_lite: RTL and testbench
===================================

# core_region_lite

Minimal AXI-Lite bus-master engine for the core region. After reset it replays a fixed boot table of register writes on its AXI-Lite master port, then services interrupts by writing the winning interrupt index to an acknowledge register and pulsing a one-hot end-of-interrupt. It sits between the interrupt sources and the system interconnect and stands in for the processor core.

## Interface
- `ADDR_WIDTH`, default 32: AXI-Lite address width.
- `DATA_WIDTH`, default 32: AXI-Lite data width.
- `IRQ_ACK_ADDR`, default 32'h1000_0000: address written on each interrupt acknowledge.
- `clk` input 1: single clock, all logic on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `irq` input 32: interrupt request lines, one per source.
- `eoi` output 32: one-hot end-of-interrupt pulse.
- `core_master` AXI_LITE interface, master side: aw/w/b/ar/r channels.

## Operation
- Write-only master.
  - `arvalid` is tied 0 and `rready` is tied 1.
  - `bready` is tied 1. B responses are accepted and ignored (posted writes); completion never waits on `bvalid`.
- Every write uses `awprot`=0 and `wstrb`=all ones.
- FSM states:
  - BOOT_ISSUE: drive the table entry; on write done, go to BOOT_GAP.
  - BOOT_GAP: one idle cycle. Go to BOOT_ISSUE if entries remain, else IDLE.
  - IDLE: if `pending` is nonzero, select the lowest set bit n and go to IRQ_ISSUE.
  - IRQ_ISSUE: write `IRQ_ACK_ADDR`, data = n zero-extended. On write done, go to EOI.
  - EOI: `eoi` = 1<<n for this cycle, clear `pending[n]`, return to IDLE.
- Boot table: `BOOT_LEN` (addr, data) pairs in the shared package, executed in index order. With `BOOT_LEN`=0, go straight to IDLE.
- Interrupt capture:
  - `irq_q` registers `irq`.
  - `pending |= irq & ~irq_q` every cycle (rising-edge detect).
  - A line already high when reset is released counts as an edge one cycle later.
- Simultaneous new edge and clear on the same bit in EOI: the set wins, so the bit stays pending.
- Interrupts arriving during boot are latched and serviced after boot, lowest index first.

## Timing
- Reset values: `awvalid`=`wvalid`=0, `awaddr`=`wdata`=0, `eoi`=0, `pending`=0, `irq_q`=0, state BOOT_ISSUE with entry index 0.
- First `awvalid` is in the first cycle after `reset` is sampled low.
- Write handshake:
  - `awvalid` and `wvalid` rise together.
  - Each channel drops independently in the cycle after its own valid&ready.
  - Address and data are stable while the respective valid is high.
  - The write is done in the cycle in which the last of the two handshakes occurs.
  - With both readies held high, a write lasts 1 cycle.
- Consecutive boot writes: at least one cycle with both valids low between them.
- `eoi` is high exactly one cycle: the cycle after the acknowledge write is done. It is never multi-hot.
- Interrupt latency with ready held high: irq edge at cycle t, pending at t+1, IRQ_ISSUE valid at t+2, `eoi` at t+3.
- Reset mid-transaction drops both valids on the next edge, discards `pending` and restarts boot at entry 0.

## Structure
- Package `core_region_pkg` holds:
  - state enum;
  - `BOOT_LEN` and the boot table as a constant array of {addr, data} structs;
  - default `IRQ_ACK_ADDR`.
- One natural sub-module, `axil_write_issuer`: takes a start pulse plus addr and data, drives the aw/w channels, and returns a one-cycle `done`.
- Top level holds the FSM, boot index, irq edge detect and the priority encoder.

## Test plan
- Reset held 50 cycles, then released; slave raises `awready`/`wready` after seeing valid. Required: all `BOOT_LEN` table writes appear in order with exact addr/data, `wstrb`=4'hF, at least one gap cycle between writes, and no `bvalid` ever needed.
- Ready delays: `awready` delayed 3 cycles, `wready` delayed 0. Required: `awvalid` held stable 3 cycles; `wvalid` drops after 1 cycle; write done when `awready` is seen.
- After boot, `irq`=32'h0000_0010 held high. Required: exactly one write to `IRQ_ACK_ADDR` with data 4, then `eoi`=32'h10 for one cycle; no second service while the line stays high.
- `irq`=32'h8000_0001 asserted in the same cycle. Required: service bit 0 then bit 31, two acknowledge writes (data 0, then 31), `eoi` 32'h1 then 32'h8000_0000.
- `irq[2]` toggles during boot. Required: latched, serviced after the last boot write.
- Reset asserted while `awvalid`=1. Required: valids low on the next edge, `pending` cleared, boot replays from entry 0.

Source files
------------

// File: rtl/core_region_pkg.sv
// Shared types and constants for the core region bus-master engine:
// FSM encoding, the boot register table and the interrupt-acknowledge address.
package core_region_pkg;

  typedef enum logic [2:0] {
    BOOT_ISSUE = 3'd0,
    BOOT_GAP   = 3'd1,
    IDLE       = 3'd2,
    IRQ_ISSUE  = 3'd3,
    EOI        = 3'd4
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } boot_entry_t;

  localparam int IRQ_LINES = 32;
  localparam int IRQ_IDX_W = 5;

  localparam int BOOT_LEN   = 4;
  // Table keeps at least one slot so an empty boot sequence still elaborates.
  localparam int BOOT_DEPTH = (BOOT_LEN > 0) ? BOOT_LEN : 1;

  localparam boot_entry_t BOOT_TABLE [BOOT_DEPTH] = '{
    '{addr: 32'h4000_0000, data: 32'h0000_0001},
    '{addr: 32'h4000_0004, data: 32'h0000_00ff},
    '{addr: 32'h4000_0010, data: 32'hdead_beef},
    '{addr: 32'h4000_0020, data: 32'h8000_0000}
  };

  localparam logic [31:0] DEFAULT_IRQ_ACK_ADDR = 32'h1000_0000;

  function automatic logic [IRQ_IDX_W-1:0] lowest_set(input logic [IRQ_LINES-1:0] vec);
    lowest_set = '0;
    for (int i = IRQ_LINES - 1; i >= 0; i--) begin
      if (vec[i]) lowest_set = IRQ_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/axi_lite.sv
// AXI-Lite bundle with master and slave views.
interface axi_lite #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    awvalid;
  logic                    awready;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    rvalid;
  logic                    rready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
           arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axil_write_issuer.sv
// Drives one AXI-Lite write on the aw/w channels per start pulse; done is
// combinational and high in the cycle the later of the two handshakes occurs.
module axil_write_issuer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata
);

  logic                  awvalid_reg;
  logic                  wvalid_reg;
  logic [ADDR_WIDTH-1:0] awaddr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  busy;

  assign busy = awvalid_reg | wvalid_reg;
  // A channel whose valid already dropped has completed its handshake.
  assign done = busy & (~awvalid_reg | awready) & (~wvalid_reg | wready);

  always_ff @(posedge clk) begin
    if (reset) begin
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      awaddr_reg  <= '0;
      wdata_reg   <= '0;
    end else if (start && !busy) begin
      awvalid_reg <= 1'b1;
      wvalid_reg  <= 1'b1;
      awaddr_reg  <= addr;
      wdata_reg   <= data;
    end else begin
      if (awvalid_reg && awready) awvalid_reg <= 1'b0;
      if (wvalid_reg && wready)   wvalid_reg  <= 1'b0;
    end
  end

  assign awvalid = awvalid_reg;
  assign awaddr  = awaddr_reg;
  assign wvalid  = wvalid_reg;
  assign wdata   = wdata_reg;

endmodule

// File: rtl/core_region_lite.sv
// Core-region stand-in: replays the boot table over AXI-Lite, then acknowledges
// edge-captured interrupts lowest index first with a one-hot end-of-interrupt.
module core_region_lite
  import core_region_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] IRQ_ACK_ADDR = ADDR_WIDTH'(DEFAULT_IRQ_ACK_ADDR)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_LINES-1:0] irq,
  output logic [IRQ_LINES-1:0] eoi,
  axi_lite.master              core_master
);

  localparam int BIDX_W = $clog2(BOOT_DEPTH + 1);

  state_t                state_reg, state_next;
  logic [BIDX_W-1:0]     boot_idx_reg, boot_idx_next;
  logic                  launch_reg;
  logic [IRQ_LINES-1:0]  irq_q_reg;
  logic [IRQ_LINES-1:0]  pending_reg, pending_next;
  logic [IRQ_LINES-1:0]  clear_mask;
  logic [IRQ_LINES-1:0]  eoi_reg, eoi_next;
  logic [IRQ_LINES-1:0]  sel_onehot;
  logic [IRQ_IDX_W-1:0]  irq_sel_reg, irq_sel_next;
  boot_entry_t           boot_entry;
  logic                  boot_more;
  logic                  issue_start;
  logic                  issue_done;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [DATA_WIDTH-1:0] issue_data;
  logic                  aw_valid, w_valid;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  unused_inputs;

  for (genvar gi = 0; gi < IRQ_LINES; gi++) begin : g_sel
    assign sel_onehot[gi] = (irq_sel_reg == IRQ_IDX_W'(gi));
  end

  always_comb begin
    boot_entry = '0;
    for (int i = 0; i < BOOT_DEPTH; i++) begin
      if (boot_idx_reg == BIDX_W'(i)) boot_entry = BOOT_TABLE[i];
    end
  end

  assign boot_more = (boot_idx_reg < BIDX_W'(BOOT_LEN));

  // The write is launched on the transition into an issue state so the
  // valids appear in the first cycle of that state.
  always_comb begin
    state_next    = state_reg;
    boot_idx_next = boot_idx_reg;
    irq_sel_next  = irq_sel_reg;
    issue_start   = 1'b0;
    issue_addr    = ADDR_WIDTH'(boot_entry.addr);
    issue_data    = DATA_WIDTH'(boot_entry.data);
    eoi_next      = '0;
    clear_mask    = '0;
    case (state_reg)
      BOOT_ISSUE: begin
        if (launch_reg) begin
          if (BOOT_LEN == 0) state_next = IDLE;
          else               issue_start = 1'b1;
        end else if (issue_done) begin
          boot_idx_next = boot_idx_reg + BIDX_W'(1);
          state_next    = BOOT_GAP;
        end
      end
      BOOT_GAP: begin
        if (boot_more) begin
          issue_start = 1'b1;
          state_next  = BOOT_ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      IDLE: begin
        if (|pending_reg) begin
          irq_sel_next = lowest_set(pending_reg);
          issue_start  = 1'b1;
          issue_addr   = IRQ_ACK_ADDR;
          issue_data   = DATA_WIDTH'(irq_sel_next);
          state_next   = IRQ_ISSUE;
        end
      end
      IRQ_ISSUE: begin
        if (issue_done) begin
          eoi_next   = sel_onehot;
          state_next = EOI;
        end
      end
      EOI: begin
        clear_mask = eoi_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // A fresh edge on a bit being cleared keeps that bit pending.
  assign pending_next = (pending_reg & ~clear_mask) | (irq & ~irq_q_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= BOOT_ISSUE;
      boot_idx_reg <= '0;
      launch_reg   <= 1'b1;
      irq_q_reg    <= '0;
      pending_reg  <= '0;
      irq_sel_reg  <= '0;
      eoi_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      boot_idx_reg <= boot_idx_next;
      launch_reg   <= 1'b0;
      irq_q_reg    <= irq;
      pending_reg  <= pending_next;
      irq_sel_reg  <= irq_sel_next;
      eoi_reg      <= eoi_next;
    end
  end

  axil_write_issuer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_issuer (
    .clk     (clk),
    .reset   (reset),
    .start   (issue_start),
    .addr    (issue_addr),
    .data    (issue_data),
    .done    (issue_done),
    .awvalid (aw_valid),
    .awready (core_master.awready),
    .awaddr  (aw_addr),
    .wvalid  (w_valid),
    .wready  (core_master.wready),
    .wdata   (w_data)
  );

  assign eoi                 = eoi_reg;
  assign core_master.awvalid = aw_valid;
  assign core_master.awaddr  = aw_addr;
  assign core_master.awprot  = 3'b000;
  assign core_master.wvalid  = w_valid;
  assign core_master.wdata   = w_data;
  assign core_master.wstrb   = '1;
  assign core_master.bready  = 1'b1;
  assign core_master.arvalid = 1'b0;
  assign core_master.araddr  = '0;
  assign core_master.arprot  = 3'b000;
  assign core_master.rready  = 1'b1;

  // Posted writes: responses and the read channel are never consumed.
  assign unused_inputs = ^{core_master.bvalid, core_master.bresp, core_master.arready,
                           core_master.rvalid, core_master.rdata, core_master.rresp};

endmodule

// File: tb/tb_core_region_lite.sv
// Randomized bench for core_region_lite: an AXI-Lite slave with adjustable
// ready delays, a bus monitor and a queue-based model of expected writes/eoi.
module tb_core_region_lite;

  localparam logic [31:0] ACK_ADDR = 32'h1000_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] irq   = '0;
  logic [31:0] eoi;

  axi_lite #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  core_region_lite #(
    .ADDR_WIDTH   (32),
    .DATA_WIDTH   (32),
    .IRQ_ACK_ADDR (ACK_ADDR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .irq         (irq),
    .eoi         (eoi),
    .core_master (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int aw_delay = 0;
  int w_delay  = 0;
  int aw_wait  = 0;
  int w_wait   = 0;

  // Slave: ready rises once valid has waited the programmed number of cycles.
  assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid && (w_wait >= w_delay);
  assign bus.bvalid  = 1'b0;
  assign bus.bresp   = 2'b00;
  assign bus.arready = 1'b0;
  assign bus.rvalid  = 1'b0;
  assign bus.rdata   = '0;
  assign bus.rresp   = 2'b00;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
    w_wait  <= (bus.wvalid && !bus.wready) ? w_wait + 1 : 0;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: expected write stream and eoi stream.
  wr_t         exp_q[$];
  logic [31:0] exp_eoi_q[$];
  int          eoi_cyc_q[$];

  task automatic push_boot();
    exp_q.push_back('{addr: 32'h4000_0000, data: 32'h0000_0001});
    exp_q.push_back('{addr: 32'h4000_0004, data: 32'h0000_00ff});
    exp_q.push_back('{addr: 32'h4000_0010, data: 32'hdead_beef});
    exp_q.push_back('{addr: 32'h4000_0020, data: 32'h8000_0000});
  endtask

  // Edges all captured together are serviced in ascending index order.
  task automatic push_service(input logic [31:0] mask);
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) begin
        exp_q.push_back('{addr: ACK_ADDR, data: 32'(i)});
        exp_eoi_q.push_back(32'h1 << i);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_quiet(input int budget);
    bit quiet;
    quiet = 1'b0;
    for (int k = 0; k < budget && !quiet; k++) begin
      tick();
      quiet = (exp_q.size() == 0) && (exp_eoi_q.size() == 0) && !bus.awvalid && !bus.wvalid;
    end
    chk("drain_in_budget", 64'(quiet), 1);
    repeat (15) tick();
  endtask

  // Bus monitor, sampled on the falling edge.
  logic        prev_awvalid = 1'b0, prev_wvalid = 1'b0;
  logic        prev_aw_hs = 1'b0, prev_w_hs = 1'b0;
  logic [31:0] prev_awaddr = '0, prev_wdata = '0, prev_eoi = '0;
  logic        aw_hs_now, w_hs_now;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];
  wr_t         got_w, exp_w;
  int          aw_rise_cyc = 0, first_aw_cyc = -1;
  int          last_aw_len = 0, last_w_len = 0, last_done_cyc = -10;

  initial begin
    forever begin
      @(negedge clk);
      aw_hs_now = bus.awvalid && bus.awready;
      w_hs_now  = bus.wvalid && bus.wready;
      if (reset) begin
        aw_q.delete();
        w_q.delete();
        aw_hs_now = 1'b0;
        w_hs_now  = 1'b0;
      end else begin
        if (bus.awvalid && !prev_awvalid) begin
          chk("valids_rise_together", 64'(bus.wvalid && !prev_wvalid), 1);
          aw_rise_cyc = cyc;
          if (first_aw_cyc < 0) first_aw_cyc = cyc;
        end
        if (prev_aw_hs) chk("aw_gap_after_write", 64'(bus.awvalid), 0);
        if (prev_w_hs)  chk("w_gap_after_write", 64'(bus.wvalid), 0);
        if (prev_awvalid && !prev_aw_hs) chk("aw_stable", {bus.awvalid, bus.awaddr}, {1'b1, prev_awaddr});
        if (prev_wvalid && !prev_w_hs)   chk("w_stable", {bus.wvalid, bus.wdata}, {1'b1, prev_wdata});
        if (aw_hs_now) begin
          aw_q.push_back(bus.awaddr);
          last_aw_len = cyc - aw_rise_cyc + 1;
        end
        if (w_hs_now) begin
          w_q.push_back(bus.wdata);
          last_w_len = cyc - aw_rise_cyc + 1;
          chk("wstrb", 64'(bus.wstrb), 4'hf);
        end
        if (aw_q.size() != 0 && w_q.size() != 0) begin
          got_w.addr    = aw_q.pop_front();
          got_w.data    = w_q.pop_front();
          last_done_cyc = cyc;
          $display("write addr=%h data=%h cycle=%0d", got_w.addr, got_w.data, cyc);
          chk("write_expected", 64'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_w = exp_q.pop_front();
            chk("write_addr", got_w.addr, exp_w.addr);
            chk("write_data", got_w.data, exp_w.data);
          end
        end
        if (eoi != 0) begin
          $display("eoi=%h cycle=%0d", eoi, cyc);
          chk("eoi_onehot", 64'($onehot(eoi)), 1);
          chk("eoi_one_cycle", prev_eoi, 0);
          chk("eoi_after_write", 64'(cyc), 64'(last_done_cyc + 1));
          chk("eoi_expected", 64'(exp_eoi_q.size() != 0), 1);
          if (exp_eoi_q.size() != 0) chk("eoi_value", eoi, exp_eoi_q.pop_front());
          eoi_cyc_q.push_back(cyc);
        end
      end
      prev_awvalid = bus.awvalid;
      prev_wvalid  = bus.wvalid;
      prev_awaddr  = bus.awaddr;
      prev_wdata   = bus.wdata;
      prev_aw_hs   = aw_hs_now;
      prev_w_hs    = w_hs_now;
      prev_eoi     = eoi;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog no completion cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  int          rel_cyc;
  int          t0;
  logic [31:0] mask;

  initial begin
    // Reset state and boot replay, with irq[2] toggling during boot.
    repeat (50) tick();
    chk("rst_awvalid", 64'(bus.awvalid), 0);
    chk("rst_wvalid", 64'(bus.wvalid), 0);
    chk("rst_awaddr", bus.awaddr, 0);
    chk("rst_wdata", bus.wdata, 0);
    chk("rst_eoi", eoi, 0);
    chk("tie_offs", {bus.arvalid, bus.rready, bus.bready, bus.awprot}, {1'b0, 1'b1, 1'b1, 3'b000});
    push_boot();
    push_service(32'h0000_0004);
    reset   = 1'b0;
    rel_cyc = cyc;
    tick(); irq = 32'h4;
    tick();
    tick(); irq = 32'h0;
    tick(); irq = 32'h4;
    tick(); irq = 32'h0;
    wait_quiet(200);
    chk("first_aw_cycle", 64'(first_aw_cyc), 64'(rel_cyc + 1));

    // awready delayed 3 cycles, wready immediate.
    aw_delay = 3;
    w_delay  = 0;
    push_service(32'h0000_0080);
    irq = 32'h80;
    tick(); irq = 32'h0;
    wait_quiet(100);
    chk("aw_valid_len", 64'(last_aw_len), 4);
    chk("w_valid_len", 64'(last_w_len), 1);
    chk("done_at_awready", 64'(last_done_cyc), 64'(aw_rise_cyc + 3));

    // Held line: single service, fixed latency.
    aw_delay = 0;
    push_service(32'h0000_0010);
    irq = 32'h10;
    t0  = cyc;
    wait_quiet(100);
    chk("irq_valid_latency", 64'(aw_rise_cyc), 64'(t0 + 2));
    chk("irq_eoi_latency", 64'(last_done_cyc + 1), 64'(t0 + 3));
    repeat (10) tick();
    irq = 32'h0;
    tick();

    // Simultaneous edges on bits 0 and 31.
    push_service(32'h8000_0001);
    irq = 32'h8000_0001;
    tick(); irq = 32'h0;
    wait_quiet(100);

    // New edge on bit 3 in the very cycle it is being cleared.
    eoi_cyc_q.delete();
    push_service(32'h8);
    push_service(32'h8);
    irq = 32'h8;
    t0  = cyc;
    tick(); irq = 32'h0;
    tick();
    tick(); irq = 32'h8;
    tick(); irq = 32'h0;
    wait_quiet(100);
    chk("set_wins_eoi_cycle", 64'(eoi_cyc_q.size() != 0 ? eoi_cyc_q[0] : -1), 64'(t0 + 3));

    // Randomized batches with random ready delays.
    for (int b = 0; b < 20; b++) begin
      aw_delay = $urandom_range(0, 3);
      w_delay  = $urandom_range(0, 3);
      mask     = $urandom & $urandom & $urandom;
      mask     = mask | (32'h1 << $urandom_range(0, 31));
      push_service(mask);
      irq = mask;
      repeat ($urandom_range(1, 10)) tick();
      irq = 32'h0;
      wait_quiet(400);
    end

    // Reset while a write is outstanding, with two interrupts pending.
    aw_delay = 6;
    w_delay  = 6;
    irq = 32'h0000_1200;
    tick(); irq = 32'h0;
    for (int k = 0; k < 20 && !bus.awvalid; k++) tick();
    chk("awvalid_before_reset", 64'(bus.awvalid), 1);
    reset = 1'b1;
    tick();
    chk("reset_drops_valids", {bus.awvalid, bus.wvalid}, 0);
    exp_q.delete();
    exp_eoi_q.delete();
    repeat (3) tick();
    aw_delay = 0;
    w_delay  = 0;
    push_boot();
    first_aw_cyc = -1;
    reset   = 1'b0;
    rel_cyc = cyc;
    wait_quiet(200);
    chk("reboot_first_aw_cycle", 64'(first_aw_cyc), 64'(rel_cyc + 1));
    chk("reboot_no_leftover_writes", 64'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
